// File: rtl/axi4s_rr_arbiter.sv
// rtl/axi4s_rr_arbiter.sv - packet-granular round-robin AXI4-Stream arbiter
// Optional output skid slice when AXI4S_ARB_OUTPUT_REG_EN is defined.
module axi4s_rr_arbiter #(
    parameter int AXI_WIDTH = 64,
    parameter int NUM_PORTS = 4,
    localparam int ID_W = $clog2(NUM_PORTS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS*AXI_WIDTH-1:0] m_tdata_i,
    input  logic [NUM_PORTS-1:0]           m_tvalid_i,
    output logic [NUM_PORTS-1:0]           m_tready_o,
    input  logic [NUM_PORTS-1:0]           m_tlast_i,
    output logic [AXI_WIDTH-1:0]           s_tdata_o,
    output logic                           s_tvalid_o,
    input  logic                           s_tready_i,
    output logic                           s_tlast_o,
    output logic [ID_W-1:0]                s_tid_o
);
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic                 r_state;
    logic [ID_W-1:0]      r_sel;
    logic [ID_W-1:0]      r_prio;

    logic [ID_W-1:0]      w_pick;
    logic [ID_W-1:0]      w_sel;
    logic [ID_W-1:0]      w_next;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_src_valid;
    logic                 w_src_ready;
    logic                 w_xfer;
    logic                 w_last;
    logic [AXI_WIDTH-1:0] w_data;

    // Reverse scan so the candidate closest to r_prio is the last one written.
    always_comb begin : pick
        int v_idx;
        w_pick = '0;
        w_any  = 1'b0;
        v_idx  = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            v_idx = int'(r_prio) + i;
            if (v_idx >= NUM_PORTS) begin
                v_idx = v_idx - NUM_PORTS;
            end
            if (m_tvalid_i[ID_W'(v_idx)]) begin
                w_any  = 1'b1;
                w_pick = ID_W'(v_idx);
            end
        end
    end

    assign w_sel   = (r_state == ST_LOCKED) ? r_sel : w_pick;
    assign w_grant = (r_state == ST_LOCKED) || w_any;
    assign w_next  = (w_sel == ID_W'(NUM_PORTS - 1)) ? '0 : w_sel + ID_W'(1);
    assign w_xfer  = w_src_valid && w_src_ready;

    always_comb begin
        w_data      = '0;
        w_last      = 1'b0;
        w_src_valid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ID_W'(k) == w_sel) begin
                w_data      = m_tdata_i[k*AXI_WIDTH +: AXI_WIDTH];
                w_last      = m_tlast_i[k];
                w_src_valid = m_tvalid_i[k] && w_grant;
            end
        end
    end

    always_comb begin
        m_tready_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if ((ID_W'(k) == w_sel) && w_grant && !rst_i) begin
                m_tready_o[k] = w_src_ready;
            end
        end
    end

    // A presented-but-stalled IDLE pick is latched into LOCKED so the output stays stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_prio  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (w_xfer && w_last) begin
                            r_prio <= w_next;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_sel   <= w_pick;
                        end
                    end
                end
                default: begin
                    if (w_xfer && w_last) begin
                        r_state <= ST_IDLE;
                        r_prio  <= w_next;
                    end
                end
            endcase
        end
    end

`ifdef AXI4S_ARB_OUTPUT_REG_EN
    logic [AXI_WIDTH-1:0] r_buf_data [2];
    logic [ID_W-1:0]      r_buf_id   [2];
    logic [1:0]           r_buf_last;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_cnt;
    logic                 w_pop;

    assign w_src_ready = (r_cnt != 2'd2);
    assign w_pop       = (r_cnt != 2'd0) && s_tready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < 2; e++) begin
                r_buf_data[e] <= '0;
                r_buf_id[e]   <= '0;
            end
            r_buf_last <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            if (w_xfer) begin
                r_buf_data[r_wr_ptr] <= w_data;
                r_buf_id[r_wr_ptr]   <= w_sel;
                r_buf_last[r_wr_ptr] <= w_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign s_tvalid_o = (r_cnt != 2'd0) && !rst_i;
    assign s_tdata_o  = r_buf_data[r_rd_ptr];
    assign s_tlast_o  = r_buf_last[r_rd_ptr] && !rst_i;
    assign s_tid_o    = rst_i ? '0 : r_buf_id[r_rd_ptr];
`else
    assign w_src_ready = s_tready_i;
    assign s_tvalid_o  = w_src_valid && !rst_i;
    assign s_tdata_o   = w_data;
    assign s_tlast_o   = w_last && !rst_i;
    assign s_tid_o     = rst_i ? '0 : w_sel;
`endif

endmodule
